// File: rtl/rob_flush_ctrl.sv
// Branch-mispredict recovery sequencer: snapshots the squashed physical tags and
// returns them to the free list N_WAY per accepted cycle while holding dispatch.
module rob_flush_ctrl #(
  parameter int N_ROB    = 32,
  parameter int N_WAY    = 2,
  parameter int CDB_BITS = 6
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_branch_haz,
  input  logic [N_ROB*CDB_BITS-1:0] i_free_list_haz,
  input  logic                      i_fl_ready,
  output logic [N_WAY-1:0]          o_fl_ret_valid,
  output logic [N_WAY*CDB_BITS-1:0] o_fl_ret_tag,
  output logic                      o_dispatch_stall,
  output logic                      o_flush_busy,
  output logic                      o_flush_done,
  output logic [$clog2(N_ROB):0]    o_flush_count
);

  localparam int IDX_W = $clog2(N_ROB);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ROB - N_WAY);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CDB_BITS-1:0]       r_buf [N_ROB];
  logic [IDX_W-1:0]          r_idx;
  logic [CNT_W-1:0]          r_count;
  logic                      w_capture;
  logic                      w_accept;
  logic                      w_last;
  logic [N_WAY-1:0]          w_valid;
  logic [N_WAY*CDB_BITS-1:0] w_tag;
  logic [CNT_W-1:0]          w_nvalid;

  // A mispredict seen outside IDLE is ignored: the stalled ROB cannot issue one legally.
  assign w_capture = (r_state == S_IDLE) && i_branch_haz;
  assign w_accept  = (r_state == S_DRAIN) && i_fl_ready;
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_branch_haz) w_state_next = S_DRAIN;
      S_DRAIN: if (i_fl_ready && w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < N_ROB; k++) r_buf[k] <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < N_ROB; k++) r_buf[k] <= i_free_list_haz[k*CDB_BITS +: CDB_BITS];
      r_idx   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_idx   <= r_idx + IDX_W'(N_WAY);
      r_count <= r_count + w_nvalid;
    end
  end

  // Lane gi always shows buffer[idx+gi]; windows never wrap because N_ROB % N_WAY == 0.
  for (genvar gi = 0; gi < N_WAY; gi++) begin : g_lane
    logic [CDB_BITS-1:0] w_lane_tag;
    assign w_lane_tag                          = r_buf[r_idx + IDX_W'(gi)];
    assign w_tag[gi*CDB_BITS +: CDB_BITS]      = w_lane_tag;
    assign w_valid[gi]                         = |w_lane_tag;
  end

  always_comb begin
    w_nvalid = '0;
    for (int i = 0; i < N_WAY; i++) w_nvalid = w_nvalid + CNT_W'(w_valid[i]);
  end

  always_comb begin
    o_fl_ret_valid   = '0;
    o_fl_ret_tag     = '0;
    o_flush_busy     = (r_state != S_IDLE);
    o_flush_done     = (r_state == S_DONE);
    o_dispatch_stall = (i_branch_haz && !i_reset) || (r_state != S_IDLE);
    if (r_state == S_DRAIN) begin
      o_fl_ret_valid = w_valid;
      o_fl_ret_tag   = w_tag;
    end
  end

  assign o_flush_count = r_count;

endmodule

// File: tb/tb_rob_flush_ctrl.sv
// Self-checking bench for rob_flush_ctrl: directed recovery scenarios plus randomized
// flushes, compared each cycle against a window-count reference model.
module tb_rob_flush_ctrl;
  localparam int N_ROB = 32;
  localparam int N_WAY = 2;
  localparam int CB    = 6;
  localparam int NWIN  = N_ROB / N_WAY;
  localparam int CW    = $clog2(N_ROB) + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  bh_in;
  logic [N_ROB*CB-1:0]   fh_in;
  logic                  rdy_in;
  logic [N_WAY-1:0]      ret_valid;
  logic [N_WAY*CB-1:0]   ret_tag;
  logic                  stall, busy, done;
  logic [CW-1:0]         fcount;

  always #5 clk = ~clk;

  rob_flush_ctrl #(.N_ROB(N_ROB), .N_WAY(N_WAY), .CDB_BITS(CB)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_branch_haz    (bh_in),
    .i_free_list_haz (fh_in),
    .i_fl_ready      (rdy_in),
    .o_fl_ret_valid  (ret_valid),
    .o_fl_ret_tag    (ret_tag),
    .o_dispatch_stall(stall),
    .o_flush_busy    (busy),
    .o_flush_done    (done),
    .o_flush_count   (fcount)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a flush is a snapshot plus the number of windows accepted so far.
  logic [CB-1:0] m_snap [N_ROB];
  bit            m_active;
  int            m_acc;
  int            m_count;
  int            cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  logic [CB-1:0] got_q [$];

  task automatic model_clear();
    for (int k = 0; k < N_ROB; k++) m_snap[k] = '0;
    m_active = 0;
    m_acc    = 0;
    m_count  = 0;
  endtask

  task automatic cycle(input logic bh, input logic [N_ROB*CB-1:0] fh, input logic rdy);
    logic [N_WAY-1:0]    exp_valid;
    logic [N_WAY*CB-1:0] exp_tag;
    bit                  draining;
    logic [CB-1:0]       t;
    bh_in  = bh;
    fh_in  = fh;
    rdy_in = rdy;
    #1;
    draining  = m_active && (m_acc < NWIN);
    exp_valid = '0;
    exp_tag   = '0;
    if (draining) begin
      for (int i = 0; i < N_WAY; i++) begin
        t = m_snap[m_acc*N_WAY + i];
        exp_tag[i*CB +: CB] = t;
        exp_valid[i]        = (t != 0);
      end
    end
    check("ret_valid", 64'(ret_valid), 64'(exp_valid));
    check("ret_tag",   64'(ret_tag),   64'(exp_tag));
    check("stall",     64'(stall),     64'(bh || m_active));
    check("busy",      64'(busy),      64'(m_active));
    check("done",      64'(done),      64'(m_active && m_acc == NWIN));
    check("count",     64'(fcount),    64'(m_count));
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      $display("flush complete at cycle %0d, count=%0d", cyc, fcount);
    end
    if (draining && rdy)
      for (int i = 0; i < N_WAY; i++)
        if (ret_valid[i]) got_q.push_back(ret_tag[i*CB +: CB]);
    @(posedge clk);
    if (!m_active) begin
      if (bh) begin
        for (int k = 0; k < N_ROB; k++) m_snap[k] = fh[k*CB +: CB];
        m_active = 1;
        m_acc    = 0;
        m_count  = 0;
      end
    end else if (m_acc < NWIN) begin
      if (rdy) begin
        for (int i = 0; i < N_WAY; i++)
          if (m_snap[m_acc*N_WAY + i] != 0) m_count++;
        m_acc++;
      end
    end else begin
      m_active = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 64'(ret_valid), 64'd0);
    check({tag, "_tag"},   64'(ret_tag),   64'd0);
    check({tag, "_stall"}, 64'(stall),     64'd0);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_done"},  64'(done),      64'd0);
    check({tag, "_count"}, 64'(fcount),    64'd0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    bh_in  = 1'b0;
    rdy_in = 1'b1;
    #1 rst = 1'b1;
    #1 check_zero_outputs(tag);
    model_clear();
    got_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc++;
  endtask

  task automatic check_returned(input string tag, input logic [N_ROB*CB-1:0] fh);
    logic [CB-1:0] exp_q [$];
    int            bad;
    logic [CB-1:0] t;
    bad = 0;
    for (int k = 0; k < N_ROB; k++) begin
      t = fh[k*CB +: CB];
      if (t != 0) exp_q.push_back(t);
    end
    check({tag, "_nret"}, 64'(got_q.size()), 64'(exp_q.size()));
    if (got_q.size() == exp_q.size())
      for (int k = 0; k < exp_q.size(); k++) if (got_q[k] != exp_q[k]) bad++;
    check({tag, "_order"}, 64'(bad), 64'd0);
  endtask

  function automatic logic [N_ROB*CB-1:0] rand_snapshot();
    logic [N_ROB*CB-1:0] v;
    v = '0;
    for (int k = 0; k < N_ROB; k++)
      if ($urandom_range(3) != 0) v[k*CB +: CB] = CB'($urandom_range(63, 1));
    return v;
  endfunction

  logic [N_ROB*CB-1:0] fh_seq, fh_sparse, fh_b;
  int                  c0, d0, limit;

  initial begin
    rst    = 1'b1;
    bh_in  = 1'b0;
    fh_in  = '0;
    rdy_in = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("rst_init");
    rst = 1'b0;

    for (int k = 0; k < N_ROB; k++) fh_seq[k*CB +: CB] = CB'(k + 1);
    fh_sparse = '0;
    fh_sparse[3*CB +: CB]  = CB'(7);
    fh_sparse[10*CB +: CB] = CB'(9);

    // Full snapshot, free list always ready.
    got_q.delete();
    c0 = cyc;
    for (int c = 0; c < 20; c++) cycle(c == 0, fh_seq, 1'b1);
    check("full_done_lat", 64'(done_cyc - c0), 64'd17);
    check("full_count", 64'(fcount), 64'd32);
    check_returned("full", fh_seq);

    // Sparse snapshot: only two tags ever returned.
    got_q.delete();
    c0 = cyc;
    for (int c = 0; c < 20; c++) cycle(c == 0, fh_sparse, 1'b1);
    check("sparse_done_lat", 64'(done_cyc - c0), 64'd17);
    check("sparse_count", 64'(fcount), 64'd2);
    check_returned("sparse", fh_sparse);

    // Back-pressure for three cycles stretches the drain by three.
    got_q.delete();
    c0 = cyc;
    for (int c = 0; c < 24; c++) cycle(c == 0, fh_seq, !(c >= 2 && c <= 4));
    check("bp_done_lat", 64'(done_cyc - c0), 64'd20);
    check("bp_count", 64'(fcount), 64'd32);
    check_returned("bp", fh_seq);

    // Reset mid-drain, then a fresh mispredict drains the new snapshot from index 0.
    for (int c = 0; c < 5; c++) cycle(c == 0, fh_seq, 1'b1);
    do_reset("rst_mid");
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    fh_b = rand_snapshot();
    c0 = cyc;
    for (int c = 0; c < 20; c++) cycle(c == 0, fh_b, 1'b1);
    check("rst_done_lat", 64'(done_cyc - c0), 64'd17);
    check_returned("rst_new", fh_b);

    // A second mispredict pulse during the drain is ignored.
    got_q.delete();
    d0 = done_cnt;
    for (int c = 0; c < 20; c++) cycle(c == 0 || c == 3, (c == 3) ? fh_b : fh_seq, 1'b1);
    check("repulse_ndone", 64'(done_cnt - d0), 64'd1);
    check_returned("repulse", fh_seq);

    // Randomized flushes with random back-pressure and spurious mispredict pulses.
    for (int f = 0; f < 8; f++) begin
      got_q.delete();
      fh_b = rand_snapshot();
      d0   = done_cnt;
      cycle(1'b1, fh_b, $urandom_range(3) != 0);
      limit = 0;
      while (m_active && limit < 300) begin
        cycle($urandom_range(7) == 0, rand_snapshot(), $urandom_range(3) != 0);
        limit++;
      end
      check("rand_timeout", 64'(limit < 300), 64'd1);
      check("rand_ndone", 64'(done_cnt - d0), 64'd1);
      check_returned("rand", fh_b);
      for (int g = 0; g < int'($urandom_range(3)); g++) cycle(1'b0, '0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
